// File: rtl/dw_conv_pkg.sv
// dw_conv_pkg: shared helpers and state type for the data-width converters
package dw_conv_pkg;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;
  function automatic int num_slots(input int dw_wide, input int dw_narrow);
    return dw_wide / dw_narrow;
  endfunction
  function automatic bit widths_ok(input int dw_wide, input int dw_narrow);
    return dw_narrow > 0 && dw_wide >= dw_narrow && dw_wide % dw_narrow == 0;
  endfunction
endpackage

// File: rtl/dw_upsizer.sv
// dw_upsizer: packs DW_IN-bit valid/ready beats (din_i/vld_i/last_i/rdy_o) LSB lane first into DW_OUT-bit words (dout_o/keep_o/last_o/vld_o/rdy_i)
module dw_upsizer
  import dw_conv_pkg::*;
#(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DW_IN-1:0]                 din_i,
  input  logic                             vld_i,
  input  logic                             last_i,
  output logic                             rdy_o,
  output logic [DW_OUT-1:0]                dout_o,
  output logic [num_slots(DW_OUT,DW_IN)-1:0] keep_o,
  output logic                             last_o,
  output logic                             vld_o,
  input  logic                             rdy_i
);
  localparam int NumSlots = num_slots(DW_OUT, DW_IN);
  localparam int PW = NumSlots > 1 ? $clog2(NumSlots) : 1;
  if (!widths_ok(DW_OUT, DW_IN)) begin : g_bad_width
    $fatal(1, "dw_upsizer: DW_OUT must be a multiple of DW_IN and >= DW_IN");
  end
  logic [DW_OUT-1:0]   acc_q, acc_d, dout_q, dout_d, merged;
  logic [NumSlots-1:0] acc_keep_q, acc_keep_d, keep_q, keep_d, merged_keep;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                acc_last_q, acc_last_d, last_q, last_d, vld_q, vld_d;
  state_e              acc_full_q, acc_full_d;
  logic                accept, complete, out_free;
  assign rdy_o  = acc_full_q == FILL;
  assign dout_o = dout_q;
  assign keep_o = keep_q;
  assign last_o = last_q;
  assign vld_o  = vld_q;
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < NumSlots; k++)
      merged[k*DW_IN +: DW_IN] = wr_ptr_q == PW'(k) ? din_i : acc_q[k*DW_IN +: DW_IN];
    merged_keep = acc_keep_q | (NumSlots'(1) << wr_ptr_q);
    accept      = vld_i & rdy_o;
    complete    = accept & (wr_ptr_q == PW'(NumSlots - 1) | last_i);
    out_free    = ~vld_q | rdy_i;
    acc_d       = acc_q;
    acc_keep_d  = acc_keep_q;
    wr_ptr_d    = wr_ptr_q;
    acc_last_d  = acc_last_q;
    acc_full_d  = acc_full_q;
    dout_d      = dout_q;
    keep_d      = keep_q;
    last_d      = last_q;
    vld_d       = vld_q & ~rdy_i;
    if (accept & ~complete) begin
      acc_d      = merged;
      acc_keep_d = merged_keep;
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end else if (complete & ~out_free) begin
      acc_d      = merged;
      acc_keep_d = merged_keep;
      acc_last_d = last_i;
      acc_full_d = FULL;
    end else if (complete | (acc_full_q == FULL & out_free)) begin
      dout_d     = complete ? merged : acc_q;
      keep_d     = complete ? merged_keep : acc_keep_q;
      last_d     = complete ? last_i : acc_last_q;
      vld_d      = 1'b1;
      acc_d      = '0;
      acc_keep_d = '0;
      wr_ptr_d   = '0;
      acc_last_d = 1'b0;
      acc_full_d = FILL;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      acc_keep_q <= '0;
      wr_ptr_q   <= '0;
      acc_last_q <= 1'b0;
      acc_full_q <= FILL;
      dout_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_keep_q <= acc_keep_d;
      wr_ptr_q   <= wr_ptr_d;
      acc_last_q <= acc_last_d;
      acc_full_q <= acc_full_d;
      dout_q     <= dout_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      vld_q      <= vld_d;
    end
  end
endmodule
